// File: rtl/mac_dot_seq.sv
// Sequential dot-product engine: accumulates N_TERMS products a*b of 4-bit
// operands into an 8-bit accumulator, with optional saturation and a sticky overflow flag.
module mac_dot_seq #(
  parameter int N_TERMS = 4,
  parameter int SAT_EN  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] acc_init,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(N_TERMS - 1);

  // Full-width sum so the carry out of the 8-bit accumulator is observable.
  function automatic logic [8:0] acc_step(input logic [7:0] acc, input logic [3:0] op_a,
                                          input logic [3:0] op_b);
    logic [7:0] prod;
    prod = {4'b0000, op_a} * {4'b0000, op_b};
    return {1'b0, acc} + {1'b0, prod};
  endfunction

  function automatic logic [7:0] acc_limit(input logic [8:0] sum9);
    logic [7:0] res;
    if ((SAT_EN != 0) && sum9[8]) begin
      res = 8'hFF;
    end else begin
      res = sum9[7:0];
    end
    return res;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic       in_ready_q, out_valid_q, busy_q;
  logic [8:0] sum9_s;

  assign sum9_s = acc_step(acc_q, a, b);

  // Next-state and datapath update for the job FSM.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = acc_init;
          count_d = 4'd0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d   = acc_limit(sum9_s);
          count_d = count_q + 4'd1;
          ovf_d   = ovf_q | sum9_s[8];
          if (count_q == LAST_CNT) begin
            state_d = DONE;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and handshake flags; handshake flags are decoded from the next state
  // so they are registered yet line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= 8'd0;
      count_q     <= 4'd0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == ACCUM);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Randomized self-checking bench: four instances with different N_TERMS/SAT_EN,
// checked cycle by cycle against a job-level arithmetic model.
module tb_mac_dot_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_s[4], in_valid_s[4], out_ready_s[4];
  logic [7:0] acc_init_s[4];
  logic [3:0] a_s[4], b_s[4];
  logic       in_ready_s[4], out_valid_s[4], overflow_s[4], busy_s[4];
  logic [7:0] result_s[4];

  int total = 0;
  int bad   = 0;
  int pa[16];
  int pb[16];

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      mac_dot_seq #(
        .N_TERMS(g == 0 ? 4 : (g == 3 ? 2 : 1)),
        .SAT_EN (g == 2 ? 1 : 0)
      ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_s[g]),
        .acc_init (acc_init_s[g]),
        .in_valid (in_valid_s[g]),
        .in_ready (in_ready_s[g]),
        .a        (a_s[g]),
        .b        (b_s[g]),
        .out_valid(out_valid_s[g]),
        .out_ready(out_ready_s[g]),
        .result   (result_s[g]),
        .overflow (overflow_s[g]),
        .busy     (busy_s[g])
      );
    end
  endgenerate

  function automatic int n_of(input int d);
    return (d == 0) ? 4 : ((d == 3) ? 2 : 1);
  endfunction

  function automatic bit sat_of(input int d);
    return (d == 2);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input int d);
    chk("rst_rdy", int'(in_ready_s[d]), 0);
    chk("rst_ov", int'(out_valid_s[d]), 0);
    chk("rst_busy", int'(busy_s[d]), 0);
    chk("rst_res", int'(result_s[d]), 0);
    chk("rst_ovf", int'(overflow_s[d]), 0);
  endtask

  task automatic rnd_ops(input int d);
    a_s[d]        = 4'($urandom_range(15, 0));
    b_s[d]        = 4'($urandom_range(15, 0));
    acc_init_s[d] = 8'($urandom_range(255, 0));
  endtask

  // One whole job on instance d using pa/pb; noise pulses controls that must be ignored.
  task automatic run_job(input int d, input int init, input int bmin, input int bmax,
                         input int bp, input bit noise);
    int acc;
    int ovf;
    int n;
    int nb;
    acc = init;
    ovf = 0;
    n   = n_of(d);
    start_s[d]    = 1'b1;
    acc_init_s[d] = 8'(init);
    tick();
    start_s[d] = 1'b0;
    chk("start_rdy", int'(in_ready_s[d]), 1);
    chk("start_busy", int'(busy_s[d]), 1);
    chk("start_res", int'(result_s[d]), init);
    chk("start_ovf", int'(overflow_s[d]), 0);
    chk("start_ov", int'(out_valid_s[d]), 0);
    for (int i = 0; i < n; i++) begin
      nb = $urandom_range(bmax, bmin);
      for (int j = 0; j < nb; j++) begin
        in_valid_s[d] = 1'b0;
        start_s[d]    = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        rnd_ops(d);
        tick();
        chk("bub_res", int'(result_s[d]), acc);
        chk("bub_rdy", int'(in_ready_s[d]), 1);
        chk("bub_ovf", int'(overflow_s[d]), ovf);
        chk("bub_ov", int'(out_valid_s[d]), 0);
      end
      rnd_ops(d);
      in_valid_s[d] = 1'b1;
      a_s[d]        = 4'(pa[i]);
      b_s[d]        = 4'(pb[i]);
      start_s[d]    = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      tick();
      in_valid_s[d] = 1'b0;
      start_s[d]    = 1'b0;
      acc = acc + pa[i] * pb[i];
      if (acc > 255) begin
        ovf = 1;
        acc = sat_of(d) ? 255 : acc - 256;
      end
      chk("acc_res", int'(result_s[d]), acc);
      chk("acc_ovf", int'(overflow_s[d]), ovf);
      chk("acc_ov", int'(out_valid_s[d]), (i == n - 1) ? 1 : 0);
      chk("acc_rdy", int'(in_ready_s[d]), (i == n - 1) ? 0 : 1);
    end
    for (int j = 0; j < bp; j++) begin
      out_ready_s[d] = 1'b0;
      in_valid_s[d]  = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      start_s[d]     = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      rnd_ops(d);
      tick();
      chk("hold_ov", int'(out_valid_s[d]), 1);
      chk("hold_res", int'(result_s[d]), acc);
      chk("hold_ovf", int'(overflow_s[d]), ovf);
      chk("hold_rdy", int'(in_ready_s[d]), 0);
    end
    out_ready_s[d] = 1'b1;
    in_valid_s[d]  = noise ? 1'($urandom_range(1, 0)) : 1'b0;
    start_s[d]     = noise ? 1'($urandom_range(1, 0)) : 1'b0;
    tick();
    out_ready_s[d] = 1'b0;
    start_s[d]     = 1'b0;
    chk("idle_ov", int'(out_valid_s[d]), 0);
    chk("idle_busy", int'(busy_s[d]), 0);
    chk("idle_rdy", int'(in_ready_s[d]), 0);
    chk("idle_res", int'(result_s[d]), acc);
    in_valid_s[d]  = noise ? 1'b1 : 1'b0;
    out_ready_s[d] = noise ? 1'b1 : 1'b0;
    rnd_ops(d);
    tick();
    in_valid_s[d]  = 1'b0;
    out_ready_s[d] = 1'b0;
    chk("idle2_busy", int'(busy_s[d]), 0);
    chk("idle2_res", int'(result_s[d]), acc);
    chk("idle2_ovf", int'(overflow_s[d]), ovf);
  endtask

  task automatic set_nominal();
    pa[0] = 3;  pb[0] = 10;
    pa[1] = 11; pb[1] = 10;
    pa[2] = 7;  pb[2] = 2;
    pa[3] = 3;  pb[3] = 2;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      start_s[d]     = 1'b0;
      in_valid_s[d]  = 1'b0;
      out_ready_s[d] = 1'b0;
      acc_init_s[d]  = 8'd0;
      a_s[d]         = 4'd0;
      b_s[d]         = 4'd0;
    end
    tick();
    tick();
    for (int d = 0; d < 4; d++) chk_zero(d);
    rst_n = 1'b1;
    tick();

    set_nominal();
    run_job(0, 10, 0, 0, 0, 1'b0);
    run_job(0, 10, 2, 2, 3, 1'b0);

    // Abort after two accepts, with start/in_valid active on the reset edge.
    start_s[0]    = 1'b1;
    acc_init_s[0] = 8'd77;
    tick();
    start_s[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_s[0] = 1'b1;
      a_s[0]        = 4'd9;
      b_s[0]        = 4'd9;
      tick();
    end
    rst_n         = 1'b0;
    start_s[0]    = 1'b1;
    out_ready_s[0] = 1'b1;
    tick();
    rst_n          = 1'b1;
    start_s[0]     = 1'b0;
    in_valid_s[0]  = 1'b0;
    out_ready_s[0] = 1'b0;
    chk_zero(0);
    tick();
    chk_zero(0);
    set_nominal();
    run_job(0, 10, 0, 0, 0, 1'b0);
    run_job(0, 10, 0, 1, 2, 1'b1);

    pa[0] = 15; pb[0] = 15;
    run_job(1, 200, 0, 0, 1, 1'b0);
    run_job(2, 200, 0, 0, 1, 1'b0);
    pa[0] = 2; pb[0] = 3;
    pa[1] = 0; pb[1] = 0;
    run_job(3, 250, 0, 0, 2, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int d;
      d = $urandom_range(3, 0);
      for (int i = 0; i < 4; i++) begin
        pa[i] = $urandom_range(15, 0);
        pb[i] = $urandom_range(15, 0);
      end
      run_job(d, $urandom_range(255, 0), 0, 2, $urandom_range(3, 0), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_dot_seq.md
MAC_DOT_SEQ -- requirements
Module: mac_dot_seq

Interface
REQ-001 SHALL have parameter N_TERMS, default 4, giving the number of products accumulated per job (legal range 1..15).
REQ-002 SHALL have parameter SAT_EN, default 0, where 0 selects 8-bit wrap on overflow and 1 selects saturation to 255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  job-start pulse; sampled only in IDLE.
REQ-006 SHALL have port acc_init  input  8  initial accumulator value; loaded on an accepted start.
REQ-007 SHALL have port in_valid  input  1  operand pair present on a/b.
REQ-008 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-009 SHALL have port a  input  4  unsigned multiplicand.
REQ-010 SHALL have port b  input  4  unsigned multiplier.
REQ-011 SHALL have port out_valid  output  1  result and overflow are valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port result  output  8  accumulated dot product.
REQ-014 SHALL have port overflow  output  1  sticky flag: some accumulate step exceeded 255 in this job.
REQ-015 SHALL have port busy  output  1  high in ACCUM or DONE.

Function
REQ-016 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-017 In IDLE: in_ready=0 and out_valid=0; start=1 loads acc<=acc_init, clears count and overflow, and moves the FSM to ACCUM next cycle.
REQ-018 In ACCUM: in_ready=1 and out_valid=0; an operand pair is accepted only on a cycle where in_valid&in_ready=1.
REQ-019 On each accept: sum9 = acc + a*b, computed as a 9-bit unsigned value (maximum 255+225=480).
REQ-020 On each accept: acc <= sum9[7:0] when SAT_EN=0, or acc <= 255 when SAT_EN=1 and sum9>255; count increments by 1.
REQ-021 On each accept: overflow <= overflow | sum9[8]; once set, overflow stays set until the next accepted start or reset.
REQ-022 Cycles with in_valid=0 in ACCUM SHALL leave acc, count and overflow unchanged (bubbles allowed).
REQ-023 The accept that makes count reach N_TERMS SHALL move the FSM to DONE next cycle; result is therefore valid 1 cycle after the final accept.
REQ-024 In DONE: out_valid=1, result=acc, in_ready=0; result and overflow SHALL hold stable until out_valid&out_ready=1, after which the FSM moves to IDLE next cycle.
REQ-025 result SHALL equal acc in every state; start outside IDLE SHALL be ignored; out_ready outside DONE SHALL be ignored; in_valid outside ACCUM SHALL be not consumed.
REQ-026 A new start SHALL be accepted no earlier than the cycle after the DONE→IDLE transition (no back-to-back job overlap).

Reset
REQ-027 When rst_n=0 at a clock edge: state=IDLE, acc=0, count=0, overflow=0; outputs in_ready=0, out_valid=0, result=0, busy=0.
REQ-028 Reset in ACCUM or DONE SHALL abort the job and discard the partial sum, with no out_valid pulse.
REQ-029 Reset SHALL take priority over start, in_valid and out_ready on the same edge.

Verification
REQ-030 Nominal job: N_TERMS=4, acc_init=10, pairs (3,10),(11,10),(7,2),(3,2) back-to-back -> out_valid 1 cycle after 4th accept, result=170, overflow=0.
REQ-031 Wrap: N_TERMS=1, SAT_EN=0, acc_init=200, pair (15,15) -> result=169, overflow=1; repeated with SAT_EN=1 -> result=255, overflow=1.
REQ-032 Bubbles and backpressure: nominal job with in_valid low 2 cycles between pairs, out_ready held low 3 cycles in DONE -> result=170 held stable with out_valid=1 throughout; IDLE entered the cycle after out_ready=1.
REQ-033 Reset mid-job: rst_n low after 2 accepts -> next cycle all outputs 0, no out_valid; a fresh job then gives the correct result, with no residue from the aborted job.
REQ-034 Ignored controls: start pulsed in ACCUM and DONE, and in_valid=1 in IDLE/DONE -> no reload, count unchanged, result unaffected.
REQ-035 Sticky overflow: N_TERMS=2, acc_init=250, pairs (2,3),(0,0) -> result=0, overflow=1 remains set in DONE.
